// File: rtl/lb_reg_responder.sv
// Local-bus register window: control, pulse, status, event counter and ID words
// behind a fixed-latency, fully pipelined read path.
module lb_reg_responder #(
    parameter logic [23:0] BASE_ADDR = 24'h010000,
    parameter int          N_RW      = 8,
    parameter int          READ_LAT  = 3,
    parameter logic [31:0] ID_WORD   = 32'h5A3C_0001
) (
    input  logic               lb_clk,
    input  logic               lb_rstn,
    input  logic               lb_strobe,
    input  logic               lb_write,
    input  logic               lb_rd,
    input  logic [23:0]        lb_addr,
    input  logic [31:0]        lb_data_out,
    output logic [31:0]        lb_din,
    output logic               resp_valid,
    output logic [N_RW*32-1:0] ctrl,
    output logic [31:0]        pulse,
    input  logic [31:0]        status,
    input  logic               event_in
);
    localparam int DLY = READ_LAT - 2;

    logic [1:0]  rdy_q, rdy_d;
    logic [31:0] ctrl_q [N_RW];
    logic [31:0] ctrl_d [N_RW];
    logic [31:0] pulse_q, pulse_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] sync1_q, sync2_q;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_inwin_q, s1_inwin_d;
    logic [3:0]  s1_off_q, s1_off_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] lb_din_q, lb_din_d;

    logic [23:0] addr_diff;
    logic        in_win, ready, wr_en, rd_en;
    logic [3:0]  off;
    logic [31:0] rd_word;
    logic        tap_v;
    logic [31:0] tap_d;

    // Subtract first so that a window near the top of the address space cannot wrap.
    assign addr_diff = lb_addr - BASE_ADDR;
    assign in_win    = (lb_addr >= BASE_ADDR) && (addr_diff[23:4] == 20'd0);
    assign off       = addr_diff[3:0];
    assign ready     = rdy_q[1];
    assign wr_en     = ready && lb_strobe && lb_write;
    assign rd_en     = ready && lb_strobe && lb_rd && !lb_write;

    always_comb begin
        rdy_d = {rdy_q[0], 1'b1};
        for (int k = 0; k < N_RW; k++) begin
            ctrl_d[k] = ctrl_q[k];
        end
        pulse_d = 32'd0;
        cnt_d   = cnt_q + {31'd0, event_in};
        if (wr_en && in_win) begin
            for (int k = 0; k < N_RW; k++) begin
                if (off == 4'(k)) begin
                    ctrl_d[k] = lb_data_out;
                end
            end
            if (off == 4'd8) begin
                pulse_d = lb_data_out;
            end
            if (off == 4'd10) begin
                cnt_d = {31'd0, event_in};
            end
        end
        s1_valid_d = rd_en;
        s1_inwin_d = in_win;
        s1_off_d   = off;
    end

    // Stage 1: the register value is sampled here, so later counter ticks do not leak in.
    always_comb begin
        rd_word = 32'd0;
        if (s1_inwin_q) begin
            case (s1_off_q)
                4'd9:    rd_word = sync2_q;
                4'd10:   rd_word = cnt_q;
                4'd11:   rd_word = ID_WORD;
                default: rd_word = 32'd0;
            endcase
            for (int k = 0; k < N_RW; k++) begin
                if (s1_off_q == 4'(k)) begin
                    rd_word = ctrl_q[k];
                end
            end
        end
    end

    generate
        if (DLY == 0) begin : g_direct
            assign tap_v = s1_valid_q;
            assign tap_d = rd_word;
        end else begin : g_delay
            logic [DLY-1:0] dv_q, dv_d;
            logic [31:0]    dd_q [DLY];
            logic [31:0]    dd_d [DLY];

            always_comb begin
                dv_d[0] = s1_valid_q;
                dd_d[0] = rd_word;
                for (int i = 1; i < DLY; i++) begin
                    dv_d[i] = dv_q[i-1];
                    dd_d[i] = dd_q[i-1];
                end
            end

            always_ff @(posedge lb_clk or negedge lb_rstn) begin
                if (!lb_rstn) begin
                    dv_q <= '0;
                    for (int i = 0; i < DLY; i++) begin
                        dd_q[i] <= 32'd0;
                    end
                end else begin
                    dv_q <= dv_d;
                    for (int i = 0; i < DLY; i++) begin
                        dd_q[i] <= dd_d[i];
                    end
                end
            end

            assign tap_v = dv_q[DLY-1];
            assign tap_d = dd_q[DLY-1];
        end
    endgenerate

    always_comb begin
        resp_valid_d = tap_v;
        lb_din_d     = tap_v ? tap_d : lb_din_q;
    end

    always_ff @(posedge lb_clk or negedge lb_rstn) begin
        if (!lb_rstn) begin
            rdy_q        <= 2'b00;
            for (int k = 0; k < N_RW; k++) begin
                ctrl_q[k] <= 32'd0;
            end
            pulse_q      <= 32'd0;
            cnt_q        <= 32'd0;
            sync1_q      <= 32'd0;
            sync2_q      <= 32'd0;
            s1_valid_q   <= 1'b0;
            s1_inwin_q   <= 1'b0;
            s1_off_q     <= 4'd0;
            resp_valid_q <= 1'b0;
            lb_din_q     <= 32'd0;
        end else begin
            rdy_q        <= rdy_d;
            for (int k = 0; k < N_RW; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
            sync1_q      <= status;
            sync2_q      <= sync1_q;
            s1_valid_q   <= s1_valid_d;
            s1_inwin_q   <= s1_inwin_d;
            s1_off_q     <= s1_off_d;
            resp_valid_q <= resp_valid_d;
            lb_din_q     <= lb_din_d;
        end
    end

    generate
        for (genvar k = 0; k < N_RW; k++) begin : g_ctrl
            assign ctrl[32*k +: 32] = ctrl_q[k];
        end
    endgenerate

    assign pulse      = pulse_q;
    assign lb_din     = lb_din_q;
    assign resp_valid = resp_valid_q;

endmodule

// File: doc/lb_reg_responder.md
LB_REG_RESPONDER -- requirements
Module: lb_reg_responder

Interface
REQ-001 Parameter BASE_ADDR, default 24'h010000: first local-bus address of the responder window.
REQ-002 Parameter N_RW, default 8: number of read/write 32-bit control registers, range 1..8.
REQ-003 Parameter READ_LAT, default 3: cycles from a read strobe to lb_din valid, range 2..4.
REQ-004 Parameter ID_WORD, default 32'h5A3C_0001: read-only identification constant.
REQ-005 Port lb_clk, input, 1: single clock; all logic rises on it.
REQ-006 Port lb_rstn, input, 1: asynchronous, active-low reset.
REQ-007 Port lb_strobe, input, 1: transaction qualifier from the local-bus initiator.
REQ-008 Port lb_write, input, 1: write when high with lb_strobe.
REQ-009 Port lb_rd, input, 1: read when high with lb_strobe.
REQ-010 Port lb_addr, input, 24: word address.
REQ-011 Port lb_data_out, input, 32: write data from the initiator.
REQ-012 Port lb_din, output, 32: read data to the initiator.
REQ-013 Port resp_valid, output, 1: one-cycle pulse that qualifies lb_din.
REQ-014 Port ctrl, output, N_RW*32: control registers, with register k at bits [32k+31:32k].
REQ-015 Port pulse, output, 32: self-clearing strobe bits.
REQ-016 Port status, input, 32: asynchronous status word.
REQ-017 Port event_in, input, 1: count-enable, synchronous to lb_clk.

Function
REQ-018 The window SHALL be offsets 0..15 from BASE_ADDR, with the following map:
- 0..N_RW-1: ctrl registers, read/write.
- 8: pulse, write-only; reads as 0.
- 9: status, read-only.
- 10: event counter, read; any write clears it.
- 11: ID_WORD, read-only.
- Other offsets in the window: read 0, writes ignored.
REQ-019 Addresses outside the window SHALL produce no register change, and lb_din SHALL read 32'h0 with resp_valid still pulsed.
REQ-020 A write SHALL take effect at the clock edge ending the cycle in which lb_strobe and lb_write are both high.
REQ-021 If lb_strobe, lb_write and lb_rd are all high together, the transaction SHALL be treated as a write only, with no resp_valid.
REQ-022 A write to offset 8 SHALL drive pulse = lb_data_out for exactly one cycle, then pulse SHALL return to 0.
REQ-023 Status SHALL pass through a two-flop synchronizer before it enters the read mux.
REQ-024 Event counter behaviour:
- 32-bit, increments by 1 per cycle while event_in is high.
- Wraps from 32'hFFFF_FFFF to 0.
- A clear coinciding with event_in SHALL yield 1.
REQ-025 Read pipeline:
- Address is captured in the strobe cycle (stage 0).
- The decoded register value is sampled at stage 1.
- lb_din and resp_valid are presented exactly READ_LAT cycles after the strobe cycle.
REQ-026 Back-to-back reads on every cycle SHALL be supported, returning one result per cycle, in order, with no bubbles.
REQ-027 A read strobed in the cycle immediately after a write to the same register SHALL return the new value.
REQ-028 lb_din SHALL hold its last value while resp_valid is low.
REQ-029 An event counter read SHALL return the value as of its stage 1 sample; increments after that point do not affect the returned word.

Reset
REQ-030 When lb_rstn is low, the following SHALL clear asynchronously to 0: ctrl, pulse, lb_din, resp_valid, the event counter, the synchronizer, and all pipeline valid bits.
REQ-031 A read in flight when reset asserts SHALL be discarded, and no resp_valid SHALL follow reset release.
REQ-032 Reset deassertion SHALL be synchronized internally; the first transaction SHALL be accepted no earlier than the 2nd lb_clk edge after lb_rstn rises.

Verification
REQ-033 Read back after a register write:
- Stimulus: write 32'hCAFE_0003 to BASE+3, then read BASE+3.
- Response: resp_valid exactly READ_LAT cycles later, with lb_din = 32'hCAFE_0003.
- Also: ctrl[127:96] = 32'hCAFE_0003 from the edge after the write.
REQ-034 Streamed reads:
- Stimulus: reads of BASE+11, BASE+9 (status = 32'h0000_00A5, held for 3 or more cycles) and BASE+20 on consecutive cycles.
- Response: three consecutive resp_valid pulses carrying 32'h5A3C_0001, 32'h0000_00A5 and 32'h0, in that order.
REQ-035 Pulse register:
- Stimulus: write 32'h0000_0011 to BASE+8.
- Response: pulse = 32'h11 for exactly one cycle, then 0; a read of BASE+8 returns 0.
REQ-036 Counter wrap and clear:
- Stimulus 1: preload the count by holding event_in high for 2^32-1 cycles (forced), then hold it 2 more cycles.
- Response 1: counter reads 1.
- Stimulus 2: write BASE+10 in the same cycle event_in is high.
- Response 2: counter reads 1.
REQ-037 Write/read collision:
- Stimulus: lb_write and lb_rd both high with the strobe, writing 32'h1234 to BASE+0.
- Response: ctrl[31:0] = 32'h1234, and no resp_valid within READ_LAT+2 cycles.
REQ-038 Reset mid-read:
- Stimulus: assert lb_rstn low for 1 cycle, one cycle after a read strobe.
- Response: no resp_valid pulse, lb_din = 0, and all ctrl = 0.
